// File: rtl/sdc_spi_byte.sv
// Byte-level SPI master (mode 0, MSB first) for the SD-card controller.
// Moves one byte per i_start, with a per-byte choice of slow (init) or fast
// SCLK rate. Owns the physical SD pins; CS simply follows i_cs_en.
module sdc_spi_byte #(
  parameter int SLOW_DIV = 125,
  parameter int FAST_DIV = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic [7:0] i_tx_data,
  input  logic       i_fast,
  input  logic       i_cs_en,
  output logic [7:0] o_rx_data,
  output logic       o_done,
  output logic       o_busy,
  input  logic       i_miso,
  output logic       o_mosi,
  output logic       o_cs,
  output logic       o_clk
);

  localparam int MAX_DIV = (SLOW_DIV > FAST_DIV) ? SLOW_DIV : FAST_DIV;
  localparam int CW      = $clog2(MAX_DIV + 1);

  // Terminal counts: a phase lasts D cycles, so the counter runs 0..D-1.
  localparam logic [CW-1:0] SLOW_TERM = CW'(SLOW_DIV - 1);
  localparam logic [CW-1:0] FAST_TERM = CW'(FAST_DIV - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    tx_sr_q, tx_sr_d;
  logic [7:0]    rx_sr_q, rx_sr_d;
  logic          fast_q, fast_d;
  logic          clk_q, clk_d;
  logic          mosi_q, mosi_d;
  logic          cs_q, cs_d;
  logic          done_q, done_d;
  logic [7:0]    rx_data_q, rx_data_d;

  logic [CW-1:0] term;
  logic          phase_end;

  assign term      = fast_q ? FAST_TERM : SLOW_TERM;
  assign phase_end = (cnt_q == term);

  // Next-state and output logic for the bit-serial transfer sequencer.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    tx_sr_d   = tx_sr_q;
    rx_sr_d   = rx_sr_q;
    fast_d    = fast_q;
    clk_d     = clk_q;
    mosi_d    = mosi_q;
    rx_data_d = rx_data_q;
    done_d    = 1'b0;
    // CS is a plain registered copy of the request, regardless of transfer.
    cs_d      = ~i_cs_en;

    case (state_q)
      IDLE: begin
        clk_d  = 1'b0;
        mosi_d = 1'b1;
        cnt_d  = '0;
        bit_d  = 3'd0;
        if (i_start) begin
          tx_sr_d = i_tx_data;
          fast_d  = i_fast;
          mosi_d  = i_tx_data[7];
          state_d = LOW;
        end
      end

      LOW: begin
        if (phase_end) begin
          cnt_d   = '0;
          clk_d   = 1'b1;
          rx_sr_d = {rx_sr_q[6:0], i_miso};
          state_d = HIGH;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      HIGH: begin
        if (phase_end) begin
          cnt_d = '0;
          clk_d = 1'b0;
          if (bit_q != 3'd7) begin
            // Falling edge: present the next bit, giving it a full low phase.
            tx_sr_d = {tx_sr_q[6:0], 1'b0};
            mosi_d  = tx_sr_q[6];
            bit_d   = bit_q + 3'd1;
            state_d = LOW;
          end else begin
            mosi_d    = 1'b1;
            rx_data_d = rx_sr_q;
            done_d    = 1'b1;
            bit_d     = 3'd0;
            state_d   = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset drops everything, including a partial byte.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= 3'd0;
      tx_sr_q   <= 8'h00;
      rx_sr_q   <= 8'h00;
      fast_q    <= 1'b0;
      clk_q     <= 1'b0;
      mosi_q    <= 1'b1;
      cs_q      <= 1'b1;
      done_q    <= 1'b0;
      rx_data_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      tx_sr_q   <= tx_sr_d;
      rx_sr_q   <= rx_sr_d;
      fast_q    <= fast_d;
      clk_q     <= clk_d;
      mosi_q    <= mosi_d;
      cs_q      <= cs_d;
      done_q    <= done_d;
      rx_data_q <= rx_data_d;
    end
  end

  assign o_busy    = (state_q != IDLE);
  assign o_done    = done_q;
  assign o_rx_data = rx_data_q;
  assign o_mosi    = mosi_q;
  assign o_cs      = cs_q;
  assign o_clk     = clk_q;

endmodule
